// File: rtl/soc_system_pio_pwm_pkg.sv
// Shared field positions and types for the PIO-driven PWM block.
package soc_system_pio_pwm_pkg;
  localparam int TOG_BIT = 11;
  localparam int CH_MSB  = 10;
  localparam int CH_LSB  = 8;
  localparam int DUTY_W  = 8;
  localparam int PCNT_W  = 8;

  typedef logic [DUTY_W-1:0] duty_t;
endpackage

// File: rtl/soc_system_pwm_tick.sv
// Prescaler and 8-bit period counter; tick/wrap are combinational strobes.
module soc_system_pwm_tick
  import soc_system_pio_pwm_pkg::*;
#(
  parameter int PRESCALE = 50
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              tick,
  output logic              wrap,
  output logic [PCNT_W-1:0] pcnt
);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;

  assign tick = (pre_cnt == PRE_MAX);
  assign wrap = tick && (pcnt == '1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      pcnt    <= '0;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
        pcnt    <= pcnt + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/soc_system_pio_pwm.sv
// Eight-channel PWM fed by a toggle-handshaked PIO command word.
module soc_system_pio_pwm
  import soc_system_pio_pwm_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int PRESCALE = 50
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [11:0]       pio_word,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              cmd_ack
);
  // Handshake: software flips pio_word[11] to issue a command; the block
  // accepts exactly one command per flip and answers by flipping cmd_ack.
  logic [11:0]       s_word;
  logic              prev_tog;
  logic              pending;
  logic [2:0]        cmd_ch;
  duty_t             cmd_duty;
  logic              tick;
  logic              wrap;
  logic [PCNT_W-1:0] pcnt;
  duty_t             shadow [NUM_CH];
  duty_t             active [NUM_CH];

  assign pending  = (s_word[TOG_BIT] != prev_tog);
  assign cmd_ch   = s_word[CH_MSB:CH_LSB];
  assign cmd_duty = s_word[DUTY_W-1:0];

  soc_system_pwm_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick),
    .wrap   (wrap),
    .pcnt   (pcnt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_word   <= '0;
      prev_tog <= 1'b0;
      cmd_ack  <= 1'b0;
    end else begin
      s_word <= pio_word;
      if (pending) begin
        prev_tog <= s_word[TOG_BIT];
        cmd_ack  <= ~cmd_ack;
      end
    end
  end

  // Channels that do not exist never match, so out-of-range writes drop out.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        shadow[i]  <= '0;
        active[i]  <= '0;
        pwm_out[i] <= 1'b0;
      end else begin
        if (pending && (cmd_ch == 3'(i))) shadow[i] <= cmd_duty;
        if (tick && wrap) active[i] <= shadow[i];
        pwm_out[i] <= (pcnt < active[i]);
      end
    end
  end
endmodule

// File: tb/tb_soc_system_pio_pwm.sv
// Directed bench for soc_system_pio_pwm with NUM_CH=4, PRESCALE=2 (512-clock period).
module tb_soc_system_pio_pwm;
  localparam int NCH = 4;

  logic           clk;
  logic           reset_n;
  logic [11:0]    pio_word;
  logic [NCH-1:0] pwm_out;
  logic           cmd_ack;

  int tests;
  int fails;
  int cyc;
  int hi [NCH];
  int ack_hi;

  soc_system_pio_pwm #(
    .NUM_CH  (NCH),
    .PRESCALE(2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pio_word(pio_word),
    .pwm_out (pwm_out),
    .cmd_ack (cmd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_out[i]);
    ack_hi += int'(cmd_ack);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic clear();
    for (int i = 0; i < NCH; i++) hi[i] = 0;
    ack_hi = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_hi(input string tag, input int e0, input int e1, input int e2, input int e3);
    chk({tag, "_ch0"}, hi[0], e0);
    chk({tag, "_ch1"}, hi[1], e1);
    chk({tag, "_ch2"}, hi[2], e2);
    chk({tag, "_ch3"}, hi[3], e3);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    reset_n  = 1'b0;
    pio_word = 12'h000;
    clear();

    // Reset state; cyc counts edges after the last reset edge.
    step(); step(); step();
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ack", cmd_ack, 0);
    reset_n = 1'b1;
    cyc = 0;
    clear();
    run_to(1024);
    chk("idle_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);
    chk("idle_ack", ack_hi, 0);

    // Single command: ch0 duty 0x80
    pio_word = 12'h880;
    step();
    chk("t2_ack_k1", cmd_ack, 0);
    step();
    chk("t2_ack_k2", cmd_ack, 1);
    clear();
    run_to(1536);
    chk("t2_prewrap_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);
    clear();
    run_to(1537);
    chk("t2_first_hi", pwm_out[0], 1);
    run_to(1792);
    chk("t2_last_hi", pwm_out[0], 1);
    run_to(1793);
    chk("t2_first_lo", pwm_out[0], 0);
    run_to(2048);
    chk_hi("t2_period", 256, 0, 0, 0);

    // Write at wrap: ch3 0x40, then 0xFF accepted on the wrap edge at 3072
    pio_word = 12'h340;
    run_to(2050);
    chk("t3_ack", cmd_ack, 0);
    run_to(2560);
    clear();
    run_to(3070);
    pio_word = 12'hBFF;
    run_to(3072);
    chk_hi("t3_p0", 256, 0, 0, 128);
    chk("t3_ack_wrap", cmd_ack, 1);
    clear();
    run_to(3584);
    chk("t3_p1_ch3", hi[3], 128);
    clear();
    run_to(4096);
    chk("t3_p2_ch3", hi[3], 510);

    // ch2 0x80 (toggle back to 0), then back-to-back ch1 writes
    pio_word = 12'h280;
    run_to(4098);
    chk("t4_ack_ch2", cmd_ack, 0);
    pio_word = 12'h910;
    step();
    pio_word = 12'h120;
    step();
    chk("t4_ack_a", cmd_ack, 1);
    pio_word = 12'h930;
    step();
    chk("t4_ack_b", cmd_ack, 0);
    step();
    chk("t4_ack_c", cmd_ack, 1);
    run_to(4608);
    clear();
    run_to(5120);
    chk_hi("t4_period", 256, 96, 256, 510);

    // Out-of-range channel 6 on a 4-channel instance
    pio_word = 12'h655;
    run_to(5122);
    chk("t5_ack", cmd_ack, 0);
    run_to(5632);
    clear();
    run_to(6144);
    chk_hi("t5_period", 256, 96, 256, 510);

    // Reset mid high phase of ch2, release with a pending command
    run_to(6244);
    chk("t6_ch2_high", pwm_out[2], 1);
    reset_n  = 1'b0;
    pio_word = 12'hA20;
    step();
    chk("t6_rst_pwm", pwm_out, 0);
    chk("t6_rst_ack", cmd_ack, 0);
    step();
    step();
    reset_n = 1'b1;
    cyc = 0;
    step();
    chk("t6_ack_k1", cmd_ack, 0);
    step();
    chk("t6_ack_k2", cmd_ack, 1);
    clear();
    run_to(512);
    chk("t6_prewrap_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);
    clear();
    run_to(1024);
    chk_hi("t6_period", 0, 0, 64, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/soc_system_pio_pwm.md
# soc_system_pio_pwm

Eight-channel, 8-bit PWM generator that sits directly downstream of the 12-bit GPIO output PIO. It consumes the PIO's `out_port` word as a toggle-handshaked command stream and drives the resulting waveforms onto DE0-Nano GPIO pins. A toggle acknowledge is returned so software can read command completion back through an input PIO.

## Interface
- `NUM_CH`, default 8: number of PWM channels (1..8).
- `PRESCALE`, default 50: clocks per PWM tick (≥1). At 50 MHz the tick is 1 MHz and the PWM period is 256 µs.
- `clk`  in  1  system clock. This is the only clock.
- `reset_n`  in  1  synchronous, active-low reset. It is sampled on the rising edge of `clk`.
- `pio_word`  in  12  command word from the PIO `out_port`.
  - `[11]`: toggle strobe.
  - `[10:8]`: channel.
  - `[7:0]`: duty.
- `pwm_out`  out  NUM_CH  PWM outputs, registered.
- `cmd_ack`  out  1  toggles once per accepted command.

## Operation
- **Input capture:** `pio_word` is registered into `s_word` every clock.
- **Command detect:** a command is pending when `s_word[11] != prev_tog`.
- **Command accept:** on the clock edge where a command is pending:
  - `shadow[s_word[10:8]] <= s_word[7:0]`;
  - `prev_tog <= s_word[11]`;
  - `cmd_ack <= ~cmd_ack`.
- **Out-of-range channel:** if the channel is ≥ NUM_CH, the shadow write is discarded, but `prev_tog` and `cmd_ack` still update. Software never hangs waiting for an acknowledge.
- **Prescaler:** `pre_cnt` counts 0..PRESCALE-1. `tick` = (`pre_cnt == PRESCALE-1`), after which `pre_cnt` returns to 0.
- **Period counter:** 8-bit `pcnt` increments on `tick` and wraps 255→0. `wrap` = `tick && pcnt == 255`.
- **Active duty:** on `wrap`, every `active[i] <= shadow[i]`. Duty changes take effect only at period boundaries, so no runt pulses occur.
- **Output compare:** `pwm_out[i] <= (pcnt < active[i])` every clock.
  - duty 0 gives constant low.
  - duty 255 gives high for 255/256 of the period.
  - duty is unsigned 8-bit; no saturation is needed.
- **Simultaneous accept and wrap:** `active` loads the old shadow value, and the new duty applies at the following wrap.
- **Repeated commands:** back-to-back commands (a toggle every clock) are all accepted. If one channel is written several times within a period, the last write wins.
- **Reset:** everything is cleared — `s_word`, `prev_tog`, `cmd_ack`, `shadow`, `active`, `pre_cnt`, `pcnt` and `pwm_out` all go to 0.
  - Reset asserted mid-period forces `pwm_out` to 0 on the next edge.
  - If `pio_word[11]` = 1 when reset releases, one command is accepted. This is required behaviour.

## Timing
- A `pio_word` change sampled at edge k lands in `s_word` at edge k.
- The shadow write and the `cmd_ack` toggle occur at edge k+1. Latency from input change to acknowledge is 2 clocks.
- The new duty becomes active at the first `wrap` after edge k+1.
- `pwm_out` reflects `active` and `pcnt` one clock later (one-cycle output register).
- The PWM period is 256·PRESCALE clocks. Each high time is `active`·PRESCALE clocks, exact.
- After reset release:
  - the first tick is at clock PRESCALE;
  - the first wrap is at clock 256·PRESCALE.

## Structure
- **Package `soc_system_pio_pwm_pkg`:**
  - field constants `TOG_BIT=11`, `CH_MSB=10`, `CH_LSB=8`, `DUTY_W=8`;
  - `PCNT_W=8`;
  - typedef `duty_t` (8-bit).
- **Sub-module `soc_system_pwm_tick`:** prescaler plus period counter. Outputs `tick`, `wrap` and `pcnt`.
- The top level holds the command decode, the shadow/active register arrays and the compare logic.

## Test plan
1. **Reset state:** PRESCALE=2, `pio_word`=0, reset for 3 clocks → `pwm_out`=0, `cmd_ack`=0, and everything stays low for 1024 clocks.
2. **Single command:** `pio_word`=0x880 (toggle=1, ch0, duty 0x80) → `cmd_ack` rises 2 clocks later. From the first wrap onward, `pwm_out[0]` is high 256 clocks and low 256 clocks per 512-clock period, and the other channels stay 0.
3. **Write at wrap:** ch3 is at duty 0x40. Write duty 0xFF timed so acceptance coincides with `wrap` → that period still shows 128 clocks high. The next period shows 510 clocks high and 2 low.
4. **Back-to-back commands:** writes to ch1 on consecutive clocks with duties 0x10, 0x20, 0x30 and toggles 1, 0, 1 → `cmd_ack` toggles 3 times, and ch1 settles at 0x30 (96 clocks high).
5. **Out-of-range channel:** NUM_CH=4, write ch6 duty 0x55 → `cmd_ack` toggles and all `pwm_out` are unchanged.
6. **Reset mid-operation:** ch2 at 0x80, assert `reset_n`=0 mid-high-phase → `pwm_out[2]`=0 on the next edge. Release with `pio_word[11]`=1, ch2, duty 0x20 → that command is accepted (`cmd_ack`=1 two clocks after release) and 64 clocks high per period from the first wrap.
